// File: rtl/regs_pkg.sv
// Register-file geometry shared by the writeback arbiter and its neighbours.
package regs_pkg;
  localparam int REG_AW = 4;
  localparam int REG_DW = 16;
  localparam int REG_N  = 1 << REG_AW;

  // Index width for n requesters; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter
  import regs_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_any
);
  int idx;

  // Scan from farthest offset down so the offset closest to ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) begin
        gnt     = '0;
        gnt[idx] = 1'b1;
        gnt_idx = IW'(idx);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter with a pending-write scoreboard for issue stalls.
module regs_wb_arbiter
  import regs_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_waddr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic                 claim_valid,
  input  logic [AW-1:0]        claim_addr,
  input  logic [AW-1:0]        chk_addr0,
  input  logic [AW-1:0]        chk_addr1,
  output logic                 stall,
  output logic [(1<<AW)-1:0]   pend_mask,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic                 claim_err
);
  localparam int IW = clog2(NREQ);

  logic [NREQ-1:0][AW-1:0] waddr_v;
  logic [NREQ-1:0][DW-1:0] wdata_v;
  logic [NREQ-1:0]         gnt;
  logic [IW-1:0]           gnt_idx, rr;
  logic                    gnt_any;
  logic [(1<<AW)-1:0]      pend_nxt;

  assign waddr_v = req_waddr;
  assign wdata_v = req_wdata;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .valid   (req_valid),
    .ptr     (rr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = rst_n ? gnt : '0;
  assign stall     = pend_mask[chk_addr0] | pend_mask[chk_addr1];

  // Clear for the committing write first, so a same-edge claim re-sets the bit.
  always_comb begin
    pend_nxt = pend_mask;
    if (rf_wen)      pend_nxt[rf_waddr]   = 1'b0;
    if (claim_valid) pend_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr        <= '0;
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      pend_mask <= '0;
      claim_err <= 1'b0;
    end else begin
      rf_wen    <= gnt_any;
      pend_mask <= pend_nxt;
      if (gnt_any) begin
        rf_waddr <= waddr_v[gnt_idx];
        rf_wdata <= wdata_v[gnt_idx];
        rr       <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (claim_valid && pend_mask[claim_addr] && !(rf_wen && rf_waddr == claim_addr))
        claim_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter against a transaction-level model of the regfile path.
module tb_regs_wb_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 4;
  localparam int DW   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*AW-1:0] req_waddr;
  logic [NREQ*DW-1:0] req_wdata;
  logic             claim_valid;
  logic [AW-1:0]    claim_addr, chk_addr0, chk_addr1;
  logic             stall;
  logic [15:0]      pend_mask;
  logic             rf_wen;
  logic [AW-1:0]    rf_waddr;
  logic [DW-1:0]    rf_wdata;
  logic             claim_err;

  int npass = 0;
  int ntot  = 0;

  regs_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .claim_valid(claim_valid),
    .claim_addr(claim_addr), .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
    .stall(stall), .pend_mask(pend_mask), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .claim_err(claim_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: the regfile itself, a set of pending registers, a pointer and the
  // write in flight between accept and commit.
  logic [15:0] mregs [16];
  logic [15:0] m_pend;
  int          m_rr;
  logic        m_wen, m_err;
  logic [3:0]  m_waddr;
  logic [15:0] m_wdata;

  initial for (int i = 0; i < 16; i++) mregs[i] = 16'h0;

  function automatic int mgrant(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    logic [15:0] p;
    if (!rst_n) begin
      m_rr <= 0; m_wen <= 1'b0; m_waddr <= '0; m_wdata <= '0; m_pend <= '0; m_err <= 1'b0;
    end else begin
      g = mgrant(req_valid, m_rr);
      p = m_pend;
      if (m_wen) begin
        p[m_waddr] = 1'b0;
        mregs[m_waddr] <= m_wdata;
      end
      if (claim_valid) begin
        if (p[claim_addr]) m_err <= 1'b1;
        p[claim_addr] = 1'b1;
      end
      m_pend <= p;
      m_wen  <= (g >= 0);
      if (g >= 0) begin
        m_waddr <= req_waddr[g*AW +: AW];
        m_wdata <= req_wdata[g*DW +: DW];
        m_rr    <= (g + 1) % NREQ;
      end
    end
  end

  always @(negedge clk) begin : compare
    int g;
    logic [NREQ-1:0] exp_rdy;
    g = mgrant(req_valid, m_rr);
    exp_rdy = (!rst_n || g < 0) ? '0 : NREQ'(1 << g);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rf_wen", 32'(rf_wen), 32'(m_wen));
    if (m_wen) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
    end
    chk("pend_mask", 32'(pend_mask), 32'(m_pend));
    chk("stall", 32'(stall), 32'(m_pend[chk_addr0] | m_pend[chk_addr1]));
    chk("claim_err", 32'(claim_err), 32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [15:0] d);
    req_waddr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_waddr = '0; req_wdata = '0;
    claim_valid = 1'b0; claim_addr = '0; chk_addr0 = '0; chk_addr1 = '0;

    // Reset state, including ready held low against valid requests.
    req_valid = 2'b11;
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wen", 32'(rf_wen), 32'h0);
    chk("rst_pend", 32'(pend_mask), 32'h0);
    chk("rst_err", 32'(claim_err), 32'h0);
    req_valid = '0;
    @(negedge clk); #1 rst_n = 1'b1;

    // Single write r3 <= BEEF.
    tick();
    set_req(0, 4'd3, 16'hBEEF); req_valid = 2'b01;
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    chk("single_wen", 32'(rf_wen), 32'h1);
    chk("single_waddr", 32'(rf_waddr), 32'h3);
    chk("single_wdata", 32'(rf_wdata), 32'hBEEF);
    tick();
    chk("single_wen_off", 32'(rf_wen), 32'h0);
    chk("single_reg3", 32'(mregs[3]), 32'hBEEF);

    // Scoreboard on r5, cleared by a write from req1 (leaves rr at 0).
    claim_valid = 1'b1; claim_addr = 4'd5;
    tick(); claim_valid = 1'b0; chk_addr0 = 4'd5; chk_addr1 = 4'd0;
    #1 chk("sb_stall_set", 32'(stall), 32'h1);
    chk("sb_pend5", 32'(pend_mask), 32'h0020);
    set_req(1, 4'd5, 16'hAAAA); req_valid = 2'b10;
    #1 chk("sb_ready1", 32'(req_ready), 32'h2);
    tick(); req_valid = '0;
    chk("sb_stall_hold", 32'(stall), 32'h1);
    tick();
    chk("sb_stall_drop", 32'(stall), 32'h0);
    chk("sb_reg5", 32'(mregs[5]), 32'hAAAA);

    // Contention: both valid for 4 cycles -> 0,1,0,1; then req1 alone granted at once.
    set_req(0, 4'd8, 16'h0808); set_req(1, 4'd9, 16'h0909); req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("cont_grant", 32'(req_ready), (i % 2) ? 32'h2 : 32'h1);
      tick();
    end
    req_valid = 2'b10;
    #1 chk("cont_solo1", 32'(req_ready), 32'h2);
    tick(); req_valid = '0;
    tick();

    // Same address from both requesters, rr=0: 1111 then 2222 lands last.
    set_req(0, 4'd2, 16'h1111); set_req(1, 4'd2, 16'h2222); req_valid = 2'b11;
    #1 chk("same_ready0", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b10;
    chk("same_wdata0", 32'(rf_wdata), 32'h1111);
    #1 chk("same_ready1", 32'(req_ready), 32'h2);
    tick(); req_valid = '0;
    chk("same_wen2", 32'(rf_wen), 32'h1);
    chk("same_wdata1", 32'(rf_wdata), 32'h2222);
    tick();
    chk("same_reg2", 32'(mregs[2]), 32'h2222);

    // Claim r7, write it, and re-claim on the commit edge.
    claim_valid = 1'b1; claim_addr = 4'd7;
    tick(); claim_valid = 1'b0;
    set_req(0, 4'd7, 16'h7777); req_valid = 2'b01;
    tick(); req_valid = '0; claim_valid = 1'b1;
    tick(); claim_valid = 1'b0;
    chk("cc_pend7", 32'(pend_mask[7]), 32'h1);
    chk("cc_err0", 32'(claim_err), 32'h0);
    claim_valid = 1'b1;
    tick(); claim_valid = 1'b0;
    chk("cc_err1", 32'(claim_err), 32'h1);
    tick(); tick();
    chk("cc_err_sticky", 32'(claim_err), 32'h1);

    // Reset while a write is in flight: it must never reach the regfile.
    set_req(0, 4'd4, 16'h4444); req_valid = 2'b01;
    tick(); req_valid = '0;
    chk("mid_wen_before", 32'(rf_wen), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("mid_wen", 32'(rf_wen), 32'h0);
    chk("mid_pend", 32'(pend_mask), 32'h0);
    chk("mid_err", 32'(claim_err), 32'h0);
    tick();
    chk("mid_reg4", 32'(mregs[4]), 32'h0);
    @(negedge clk); #1 rst_n = 1'b1;
    tick(); tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
